// File: rtl/instr_prefetch_queue_if.sv
// instr_prefetch_queue_if: fetch-stage bus joining the prefetch queue, instruction memory and ID.
interface instr_prefetch_queue_if #(
    parameter int DEPTH = 4,
    parameter int AW    = 11,
    parameter int DW    = 32
);
    localparam int CW = $clog2(DEPTH + 1);
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic [AW-1:0] I_ADDR;
    logic          im_oen;
    logic [DW-1:0] IR;
    logic [DW-1:0] ir_out;
    logic [AW-1:0] pc_out;
    logic          ir_valid;
    logic          ir_ready;
    logic [CW-1:0] count;
    modport slave (
        input  redirect, redirect_pc, IR, ir_ready,
        output I_ADDR, im_oen, ir_out, pc_out, ir_valid, count
    );
    modport master (
        output redirect, redirect_pc, IR, ir_ready,
        input  I_ADDR, im_oen, ir_out, pc_out, ir_valid, count
    );
endinterface

// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue: fetches from synchronous instruction memory into a small PC-tagged FIFO feeding ID.
module instr_prefetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 11,
    parameter int DW    = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    instr_prefetch_queue_if.slave   bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    logic [DW-1:0] r_ir_mem [DEPTH];
    logic [AW-1:0] r_pc_mem [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_fpc;
    logic [AW-1:0] r_addr;
    logic [AW-1:0] r_req_pc;
    logic          r_rsp_pend;
    logic          r_redirect_q;
    logic          w_issue;
    logic          w_valid;
    logic          w_pop;
    // Credit counts the word in flight, so a push can never land on a full queue.
    assign w_issue      = ~rst & ~r_redirect_q & ((r_count + CW'(r_rsp_pend)) < CW'(DEPTH));
    assign w_valid      = ~rst & (r_count != '0);
    assign w_pop        = w_valid & bus.ir_ready;
    assign bus.im_oen   = ~w_issue;
    assign bus.I_ADDR   = rst ? '0 : (w_issue ? r_fpc : r_addr);
    assign bus.ir_valid = w_valid;
    assign bus.ir_out   = w_valid ? r_ir_mem[r_rd_ptr] : '0;
    assign bus.pc_out   = w_valid ? r_pc_mem[r_rd_ptr] : '0;
    assign bus.count    = r_count;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fpc        <= '0;
            r_addr       <= '0;
            r_req_pc     <= '0;
            r_count      <= '0;
            r_rsp_pend   <= 1'b0;
            r_redirect_q <= 1'b0;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
        end else begin
            r_redirect_q <= bus.redirect;
            if (w_issue) begin
                r_addr   <= r_fpc;
                r_req_pc <= r_fpc;
            end
            if (bus.redirect) begin
                r_fpc      <= bus.redirect_pc;
                r_rsp_pend <= 1'b0;
                r_count    <= '0;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
            end else begin
                r_fpc      <= w_issue ? r_fpc + 1'b1 : r_fpc;
                r_rsp_pend <= w_issue;
                r_wr_ptr   <= r_rsp_pend ? r_wr_ptr + 1'b1 : r_wr_ptr;
                r_rd_ptr   <= w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;
                r_count    <= r_count + CW'(r_rsp_pend) - CW'(w_pop);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (r_rsp_pend) begin
            r_ir_mem[r_wr_ptr] <= bus.IR;
            r_pc_mem[r_wr_ptr] <= r_req_pc;
        end
    end
endmodule

// File: tb/tb_instr_prefetch_queue.sv
// tb_instr_prefetch_queue: scoreboard bench checking the delivered instruction stream against a PC-sequence model.
module tb_instr_prefetch_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 11;
    localparam int DW    = 32;
    logic          clk = 1'b0;
    logic          rst;
    int            n_chk  = 0;
    int            n_pass = 0;
    int            n_pops = 0;
    int            p0;
    logic [AW-1:0] exp_q[$];
    instr_prefetch_queue_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus();
    instr_prefetch_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
        return 32'h100 + DW'(a);
    endfunction
    // Synchronous memory: data for a read appears the cycle after, garbage otherwise.
    always @(posedge clk) bus.IR <= bus.im_oen ? DW'($urandom) : mem(bus.I_ADDR);
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask
    // The architectural stream after a (re)start is simply start, start+1, ... wrapping mod 2^AW.
    task automatic refill(input logic [AW-1:0] pc);
        exp_q.delete();
        for (int i = 0; i < 1024; i++) exp_q.push_back(pc + AW'(i));
    endtask
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask
    task automatic smp();
        @(negedge clk);
    endtask
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            chk("count_bound", 32'(bus.count <= 3'(DEPTH)), 32'd1);
            if (bus.ir_valid && bus.ir_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL scoreboard_underrun: popped pc %0h with nothing expected", bus.pc_out);
                end else begin
                    logic [AW-1:0] e;
                    e = exp_q.pop_front();
                    chk("pc_out", 32'(bus.pc_out), 32'(e));
                    chk("ir_out", bus.ir_out, mem(e));
                    n_pops++;
                end
            end else if (!bus.ir_valid) begin
                chk("nop_ir_out", bus.ir_out, 32'd0);
                chk("nop_pc_out", 32'(bus.pc_out), 32'd0);
            end
        end
    end
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end
    initial begin
        rst = 1'b1;
        bus.redirect = 1'b0;
        bus.redirect_pc = '0;
        bus.ir_ready = 1'b1;
        nxt(); smp();
        chk("rst_oen", 32'(bus.im_oen), 32'd1);
        chk("rst_addr", 32'(bus.I_ADDR), 32'd0);
        chk("rst_valid", 32'(bus.ir_valid), 32'd0);
        chk("rst_ir", bus.ir_out, 32'd0);
        chk("rst_pc", 32'(bus.pc_out), 32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);
        // cold start
        nxt(); rst = 1'b0; refill('0); smp();
        chk("t1_c1_valid", 32'(bus.ir_valid), 32'd0);
        chk("t1_c1_oen", 32'(bus.im_oen), 32'd0);
        chk("t1_c1_addr", 32'(bus.I_ADDR), 32'd0);
        nxt(); smp();
        chk("t1_c2_valid", 32'(bus.ir_valid), 32'd0);
        nxt(); smp();
        chk("t1_c3_valid", 32'(bus.ir_valid), 32'd1);
        chk("t1_c3_pc", 32'(bus.pc_out), 32'd0);
        repeat (3) begin
            nxt(); smp();
            chk("t1_stream", 32'(bus.ir_valid), 32'd1);
        end
        // backpressure
        nxt(); bus.ir_ready = 1'b0; smp();
        repeat (9) begin
            nxt(); smp();
        end
        chk("t2_count_full", 32'(bus.count), 32'(DEPTH));
        chk("t2_oen_stall", 32'(bus.im_oen), 32'd1);
        chk("t2_valid_held", 32'(bus.ir_valid), 32'd1);
        nxt(); bus.ir_ready = 1'b1; smp();
        repeat (8) begin
            nxt(); smp();
            chk("t2_no_gap", 32'(bus.ir_valid), 32'd1);
        end
        // redirect with three entries queued
        nxt(); bus.ir_ready = 1'b0; rst = 1'b1; smp();
        nxt(); rst = 1'b0; refill('0); smp();
        repeat (3) begin
            nxt(); smp();
        end
        nxt(); bus.redirect = 1'b1; bus.redirect_pc = 11'h040; smp();
        chk("t3_count_pre", 32'(bus.count), 32'd3);
        nxt(); bus.redirect = 1'b0; refill(11'h040); bus.ir_ready = 1'b1; smp();
        chk("t3_t1_count", 32'(bus.count), 32'd0);
        chk("t3_t1_valid", 32'(bus.ir_valid), 32'd0);
        chk("t3_t1_oen", 32'(bus.im_oen), 32'd1);
        nxt(); smp();
        chk("t3_t2_oen", 32'(bus.im_oen), 32'd0);
        chk("t3_t2_addr", 32'(bus.I_ADDR), 32'h040);
        chk("t3_t2_valid", 32'(bus.ir_valid), 32'd0);
        nxt(); smp();
        chk("t3_t3_valid", 32'(bus.ir_valid), 32'd0);
        nxt(); smp();
        chk("t3_t4_valid", 32'(bus.ir_valid), 32'd1);
        chk("t3_t4_pc", 32'(bus.pc_out), 32'h040);
        // back-to-back redirects, the last one wrapping past the top of memory
        nxt(); bus.redirect = 1'b1; bus.redirect_pc = 11'h123; smp();
        nxt(); refill(11'h123); bus.redirect_pc = 11'h7FE; smp();
        nxt(); bus.redirect = 1'b0; refill(11'h7FE); smp();
        p0 = n_pops;
        repeat (8) begin
            nxt(); smp();
        end
        chk("t4_progress", 32'(n_pops - p0 >= 4), 32'd1);
        // random ready with occasional redirects
        p0 = n_pops;
        repeat (500) begin
            nxt();
            if (bus.redirect) refill(bus.redirect_pc);
            bus.ir_ready = 1'($urandom_range(0, 1));
            bus.redirect = ($urandom_range(0, 39) == 0);
            bus.redirect_pc = AW'($urandom);
            smp();
        end
        nxt();
        if (bus.redirect) refill(bus.redirect_pc);
        bus.redirect = 1'b0;
        smp();
        chk("t5_progress", 32'(n_pops - p0 > 100), 32'd1);
        // reset together with redirect while two entries are queued and a read is in flight
        nxt(); bus.ir_ready = 1'b0; rst = 1'b1; smp();
        nxt(); rst = 1'b0; refill('0); smp();
        nxt(); smp();
        nxt(); smp();
        chk("t6_read_in_flight", 32'(bus.im_oen), 32'd0);
        nxt(); rst = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 11'h200; smp();
        chk("t6_count_pre", 32'(bus.count), 32'd2);
        chk("t6_rst_valid", 32'(bus.ir_valid), 32'd0);
        chk("t6_rst_oen", 32'(bus.im_oen), 32'd1);
        nxt(); rst = 1'b0; bus.redirect = 1'b0; refill('0); bus.ir_ready = 1'b1; smp();
        chk("t6_count", 32'(bus.count), 32'd0);
        chk("t6_valid", 32'(bus.ir_valid), 32'd0);
        chk("t6_oen", 32'(bus.im_oen), 32'd0);
        chk("t6_addr", 32'(bus.I_ADDR), 32'd0);
        nxt(); smp();
        chk("t6_c2_valid", 32'(bus.ir_valid), 32'd0);
        nxt(); smp();
        chk("t6_c3_valid", 32'(bus.ir_valid), 32'd1);
        chk("t6_c3_pc", 32'(bus.pc_out), 32'd0);
        repeat (4) begin
            nxt(); smp();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
